// File: rtl/sha256_pkg.sv
// Shared definitions for the sha256 core arbiter.
//   HASH_W / BYTE_W : digest and message-byte widths of the shared sha256 core
//   CNT_W           : width of the per-grant idle (timeout) counter
//   state_e         : arbiter FSM states
//   onehot_to_idx   : index of the set bit in a one-hot vector of up to 8 bits
package sha256_pkg;

    localparam int unsigned HASH_W = 256;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        CORE_RST,
        STREAM,
        WAIT_DONE,
        DELIVER
    } state_e;

    function automatic int unsigned onehot_to_idx(input logic [7:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (onehot[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
//   req   : request vector, one bit per requester
//   last  : index of the most recently granted requester
//   grant : one-hot winner, searching from last+1 upward and wrapping to 0;
//           zero when no request is pending
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic [NUM_REQ-1:0]         grant
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        // Offset NUM_REQ lands back on last itself, so a lone requester still wins.
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = IDX_W'((32'(last) + off) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sha256_core_arbiter.sv
// Shares one sha256 core between NUM_REQ requesters.
//   clk, reset            : clock and synchronous active-high reset
//   req                   : per-requester level request, held until hash_valid or abort
//   req_byte/_valid/_done : per-requester message byte stream and end-of-message pulse
//   grant                 : one-hot current owner of the core (zero when free)
//   req_ready             : byte from requester i accepted this cycle
//   hash_valid            : one-cycle pulse, hash_out belongs to requester i
//   abort                 : one-cycle pulse, requester i dropped for going idle too long
//   hash_out              : last captured digest
//   core_*                : connection to the shared sha256 core
module sha256_core_arbiter
    import sha256_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*BYTE_W-1:0] req_byte,
    input  logic [NUM_REQ-1:0]        req_byte_valid,
    input  logic [NUM_REQ-1:0]        req_bytes_done,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        hash_valid,
    output logic [NUM_REQ-1:0]        abort,
    output logic [HASH_W-1:0]         hash_out,
    output logic                      core_reset,
    output logic [BYTE_W-1:0]         core_byte_in,
    output logic                      core_byte_valid,
    output logic                      core_bytes_done,
    input  logic                      core_ready_for_bytes,
    input  logic                      core_done,
    input  logic [HASH_W-1:0]         core_hash
);

    localparam int unsigned      IDX_W    = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]    gidx_q, gidx_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [HASH_W-1:0]   hash_q, hash_d;
    logic [NUM_REQ-1:0]  abort_q, abort_d;
    logic                core_rst_q, core_rst_d;

    logic [NUM_REQ-1:0]  winner;
    logic [IDX_W-1:0]    winner_idx;
    logic                byte_acc;
    logic                req_held;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req   (req),
        .last  (last_q),
        .grant (winner)
    );

    assign winner_idx = IDX_W'(onehot_to_idx(8'(winner)));

    // Stream mux: only the granted requester reaches the core, and only in STREAM.
    always_comb begin
        core_byte_in    = '0;
        core_byte_valid = 1'b0;
        core_bytes_done = 1'b0;
        req_ready       = '0;
        byte_acc        = 1'b0;
        if (state_q == STREAM) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (grant_q[i]) begin
                    core_byte_in = req_byte[i*BYTE_W +: BYTE_W];
                end
            end
            core_byte_valid = |(grant_q & req_byte_valid);
            core_bytes_done = |(grant_q & req_bytes_done);
            req_ready       = grant_q & req_byte_valid & {NUM_REQ{core_ready_for_bytes}};
            byte_acc        = |req_ready;
        end
    end

    assign req_held = |(grant_q & req);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        hash_d     = hash_q;
        abort_d    = '0;
        core_rst_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = winner;
                    gidx_d  = winner_idx;
                    state_d = CORE_RST;
                end
            end
            CORE_RST: begin
                cnt_d   = '0;
                state_d = STREAM;
            end
            STREAM: begin
                cnt_d = byte_acc ? '0 : cnt_q + 1'b1;
                if (!req_held) begin
                    // Requester withdrew: silent abort.
                    grant_d    = '0;
                    last_d     = gidx_q;
                    core_rst_d = 1'b1;
                    state_d    = IDLE;
                end else if (core_bytes_done) begin
                    state_d = WAIT_DONE;
                end else if (!byte_acc && cnt_q == CNT_MAX) begin
                    abort_d    = grant_q;
                    grant_d    = '0;
                    last_d     = gidx_q;
                    core_rst_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!req_held) begin
                    grant_d    = '0;
                    last_d     = gidx_q;
                    core_rst_d = 1'b1;
                    state_d    = IDLE;
                end else if (core_done) begin
                    hash_d  = core_hash;
                    state_d = DELIVER;
                end
            end
            DELIVER: begin
                grant_d = '0;
                last_d  = gidx_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            last_q     <= LAST_RST;
            cnt_q      <= '0;
            hash_q     <= '0;
            abort_q    <= '0;
            // Keeps the core in reset for one extra cycle after reset releases.
            core_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            hash_q     <= hash_d;
            abort_q    <= abort_d;
            core_rst_q <= core_rst_d;
        end
    end

    assign grant      = grant_q;
    assign abort      = abort_q;
    assign hash_out   = hash_q;
    assign hash_valid = (state_q == DELIVER) ? grant_q : '0;
    assign core_reset = reset | core_rst_q | (state_q == CORE_RST);

endmodule

// File: tb/tb_sha256_core_arbiter.sv
// Self-checking bench for sha256_core_arbiter with a behavioural stand-in for the
// sha256 core: it returns the real digests of "abc" and "", and a tagged pattern
// for any other message.
`timescale 1ns/1ps
module tb_sha256_core_arbiter;
    import sha256_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 16;
    localparam logic [255:0] H_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] H_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req, req_byte_valid, req_bytes_done;
    logic [N*8-1:0] req_byte;
    logic [N-1:0]   grant, req_ready, hash_valid, abort;
    logic [255:0]   hash_out;
    logic           core_reset;
    logic [7:0]     core_byte_in;
    logic           core_byte_valid, core_bytes_done;
    logic           core_ready_for_bytes, core_done;
    logic [255:0]   core_hash;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sha256_core_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .req                  (req),
        .req_byte             (req_byte),
        .req_byte_valid       (req_byte_valid),
        .req_bytes_done       (req_bytes_done),
        .grant                (grant),
        .req_ready            (req_ready),
        .hash_valid           (hash_valid),
        .abort                (abort),
        .hash_out             (hash_out),
        .core_reset           (core_reset),
        .core_byte_in         (core_byte_in),
        .core_byte_valid      (core_byte_valid),
        .core_bytes_done      (core_bytes_done),
        .core_ready_for_bytes (core_ready_for_bytes),
        .core_done            (core_done),
        .core_hash            (core_hash)
    );

    function automatic logic [255:0] model_hash(input int len, input logic [7:0] b0,
                                                input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] c0, c1, c2;
        c0 = (len > 0) ? b0 : 8'h00;
        c1 = (len > 1) ? b1 : 8'h00;
        c2 = (len > 2) ? b2 : 8'h00;
        if (len == 0) return H_EMPTY;
        if (len == 3 && c0 == 8'h61 && c1 == 8'h62 && c2 == 8'h63) return H_ABC;
        return {8'(len), c0, c1, c2, {28{8'h5a}}};
    endfunction

    function automatic logic [7:0] byte_of(input logic [23:0] m, input int i);
        return m[23-8*i -: 8];
    endfunction

    // Core stand-in: collects bytes, answers core_done 3 cycles after bytes_done.
    logic [7:0] mbuf [3];
    int         mlen;
    int         done_cnt;
    always @(posedge clk) begin
        core_done <= 1'b0;
        if (core_reset) begin
            mlen      <= 0;
            done_cnt  <= 0;
            core_hash <= '0;
        end else begin
            if (core_byte_valid && core_ready_for_bytes) begin
                if (mlen < 3) mbuf[mlen] <= core_byte_in;
                mlen <= mlen + 1;
            end
            if (core_bytes_done) done_cnt <= 3;
            else if (done_cnt > 0) done_cnt <= done_cnt - 1;
            if (done_cnt == 1) begin
                core_done <= 1'b1;
                core_hash <= model_hash(mlen, mbuf[0], mbuf[1], mbuf[2]);
            end
        end
    end

    typedef struct {
        logic [N-1:0] req;
        int           len;
        logic [23:0]  msg;
        logic [N-1:0] exp_grant;
        logic [255:0] exp_hash;
    } vec_t;

    function automatic vec_t mk(input logic [N-1:0] r, input int len, input logic [23:0] m,
                                input logic [N-1:0] g);
        vec_t v;
        v.req       = r;
        v.len       = len;
        v.msg       = m;
        v.exp_grant = g;
        v.exp_hash  = model_hash(len, byte_of(m, 0), byte_of(m, 1), byte_of(m, 2));
        return v;
    endfunction

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        req            = '0;
        req_byte       = '0;
        req_byte_valid = '0;
        req_bytes_done = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_grant();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (grant != '0) break;
        end
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int g;
        g = 0;
        for (int i = 0; i < int'(N); i++) if (v.exp_grant[i]) g = i;
        req = v.req;
        wait_grant();
        check({nm, "_grant"}, 256'(grant), 256'(v.exp_grant));
        @(negedge clk);  // CORE_RST done, now in STREAM
        if (v.len == 0) begin
            req_bytes_done[g] = 1'b1;
            @(negedge clk);
        end else begin
            for (int i = 0; i < v.len; i++) begin
                req_byte_valid       = '1;  // non-granted valids must be ignored
                req_byte             = {N{8'hee}};
                req_byte[g*8 +: 8]   = byte_of(v.msg, i);
                req_bytes_done[g]    = (i == v.len - 1);
                #1;
                check({nm, "_ready"}, 256'(req_ready), 256'(v.exp_grant));
                @(negedge clk);
            end
        end
        req_byte_valid = '0;
        req_bytes_done = '0;
        for (int k = 0; k < 30; k++) begin
            if (hash_valid != '0) break;
            @(negedge clk);
        end
        check({nm, "_hv"}, 256'(hash_valid), 256'(v.exp_grant));
        check({nm, "_hash"}, hash_out, v.exp_hash);
    endtask

    vec_t vecs [10];
    int   n;
    int   bad;

    initial begin
        core_ready_for_bytes = 1'b1;

        vecs[0] = mk(4'b1111, 3, 24'h616263, 4'b0001);
        vecs[1] = mk(4'b1111, 0, 24'h000000, 4'b0010);
        vecs[2] = mk(4'b1111, 1, 24'h780000, 4'b0100);
        vecs[3] = mk(4'b1111, 2, 24'h686900, 4'b1000);
        vecs[4] = mk(4'b1111, 3, 24'h616263, 4'b0001);
        vecs[5] = mk(4'b0001, 3, 24'h616263, 4'b0001);
        vecs[6] = mk(4'b0001, 0, 24'h000000, 4'b0001);
        vecs[7] = mk(4'b1000, 1, 24'h710000, 4'b1000);
        vecs[8] = mk(4'b0101, 2, 24'h616200, 4'b0001);
        vecs[9] = mk(4'b0110, 1, 24'h7a0000, 4'b0010);

        // Reset values.
        reset          = 1'b1;
        req            = '0;
        req_byte       = '0;
        req_byte_valid = '0;
        req_bytes_done = '0;
        repeat (3) @(negedge clk);
        check("rst_grant", 256'(grant), 256'(0));
        check("rst_hv", 256'(hash_valid), 256'(0));
        check("rst_abort", 256'(abort), 256'(0));
        check("rst_ready", 256'(req_ready), 256'(0));
        check("rst_hash", hash_out, 256'(0));
        check("rst_cnt", 256'(dut.cnt_q), 256'(0));
        check("rst_core_rst", 256'(core_reset), 256'(1));
        reset = 1'b0;
        #1;
        check("core_rst_after", 256'(core_reset), 256'(1));
        @(negedge clk);
        check("core_rst_clear", 256'(core_reset), 256'(0));

        for (int i = 0; i < 10; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Timeout: requester 2 idles, aborts 16 cycles after entering STREAM.
        do_reset();
        req = 4'b1100;
        wait_grant();
        check("to_grant", 256'(grant), 256'(4'b0100));
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            n++;
            if (abort != '0) break;
        end
        check("to_latency", 256'(n), 256'(17));
        check("to_abort", 256'(abort), 256'(4'b0100));
        check("to_core_rst", 256'(core_reset), 256'(1));
        check("to_grant_clr", 256'(grant), 256'(0));
        req = 4'b1000;
        @(negedge clk);
        check("to_abort_pulse", 256'(abort), 256'(0));
        check("to_next_grant", 256'(grant), 256'(4'b1000));

        // Byte and bytes_done together, then reset while waiting for the core.
        do_reset();
        run_vec("pre", mk(4'b0001, 0, 24'h000000, 4'b0001));
        req = 4'b0010;
        wait_grant();
        check("bd_grant", 256'(grant), 256'(4'b0010));
        @(negedge clk);
        req_byte          = '0;
        req_byte[15:8]    = 8'h63;
        req_byte_valid    = 4'b0010;
        req_bytes_done    = 4'b0010;
        #1;
        check("bd_byte", 256'(core_byte_in), 256'(8'h63));
        check("bd_valid", 256'(core_byte_valid), 256'(1));
        check("bd_done", 256'(core_bytes_done), 256'(1));
        check("bd_ready", 256'(req_ready), 256'(4'b0010));
        @(negedge clk);
        req_byte_valid = '0;
        req_bytes_done = '0;
        check("bd_state", 256'(dut.state_q), 256'(WAIT_DONE));
        reset = 1'b1;
        req   = '0;
        bad   = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 1) reset = 1'b0;
            if (hash_valid != '0) bad = 1;
        end
        check("rw_no_hv", 256'(bad), 256'(0));
        check("rw_grant", 256'(grant), 256'(0));
        req = 4'b0011;
        wait_grant();
        check("rw_next_grant", 256'(grant), 256'(4'b0001));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

endmodule

// File: doc/sha256_core_arbiter.md
SHA256_CORE_ARBITER -- requirements
Module: sha256_core_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-002 The block SHALL have parameter NUM_REQ, default 4, the number of requesters (2..8).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, the maximum idle cycles for a granted requester.
REQ-004 Port clk  input  1  system clock, all logic on rising edge.
REQ-005 Port reset  input  1  synchronous active-high reset.
REQ-006 Port req  input  NUM_REQ  per-requester hash request, level, held until hash_valid or abort.
REQ-007 Port req_byte  input  NUM_REQ*8  per-requester message byte; slice i belongs to requester i.
REQ-008 Port req_byte_valid  input  NUM_REQ  per-requester byte valid.
REQ-009 Port req_bytes_done  input  NUM_REQ  per-requester end-of-message, one-cycle pulse.
REQ-010 Port grant  output  NUM_REQ  one-hot owner of the core, or zero.
REQ-011 Port req_ready  output  NUM_REQ  byte accepted this cycle by requester i.
REQ-012 Port hash_valid  output  NUM_REQ  one-cycle pulse: hash_out belongs to requester i.
REQ-013 Port abort  output  NUM_REQ  one-cycle pulse: request i dropped on timeout.
REQ-014 Port hash_out  output  256  captured digest, held until the next capture.
REQ-015 Port core_reset, core_byte_in[8], core_byte_valid, core_bytes_done  output  drive the shared sha256 core.
REQ-016 Port core_ready_for_bytes, core_done, core_hash[256]  input  returned from the shared sha256 core.

Function
REQ-017 FSM states SHALL be IDLE, CORE_RST, STREAM, WAIT_DONE, DELIVER.
REQ-018 IDLE: when any req is high, the block SHALL pick a winner round-robin, starting at the index after the last granted one, register a one-hot grant, and go to CORE_RST.
REQ-019 CORE_RST SHALL assert core_reset for exactly one cycle, then go to STREAM.
REQ-020 STREAM: core_byte_in, core_byte_valid, and core_bytes_done SHALL combinationally mux from the granted requester; all other core inputs SHALL be zero.
REQ-021 req_ready[g] SHALL equal core_ready_for_bytes & req_byte_valid[g] in STREAM, and 0 otherwise; non-granted req_ready SHALL be 0.
REQ-022 A byte and bytes_done presented in the same cycle SHALL both be forwarded; bytes_done SHALL move the FSM to WAIT_DONE.
REQ-023 WAIT_DONE: on core_done high, the block SHALL register core_hash into hash_out and go to DELIVER.
REQ-024 DELIVER SHALL pulse hash_valid[g] for one cycle, clear grant, record g as last granted, and return to IDLE.
REQ-025 Latency: a winner's req seen in IDLE SHALL produce grant on the next edge, and its first byte SHALL be acceptable 2 cycles after the grant.
REQ-026 A 16-bit idle counter SHALL clear on every accepted byte and on entry to STREAM, and increment in STREAM on any cycle without an accepted byte.
REQ-027 When the counter reaches TIMEOUT_CYCLES-1, the block SHALL pulse abort[g], clear grant, assert core_reset for one cycle, record g as last granted, and go to IDLE.
REQ-028 If req[g] drops in STREAM or WAIT_DONE, the block SHALL treat it as an abort without the abort pulse: core_reset is asserted and the FSM goes to IDLE.
REQ-029 Round-robin SHALL wrap from index NUM_REQ-1 to 0.
REQ-030 With a single active requester, it SHALL be re-granted after every completion.
REQ-031 Requests arriving outside IDLE SHALL wait; no preemption.

Reset
REQ-032 On reset the block SHALL enter IDLE and set last granted to NUM_REQ-1, so index 0 has first priority.
REQ-033 On reset, grant, hash_valid, abort, and req_ready SHALL be 0, hash_out SHALL be 0, and the counter SHALL be 0.
REQ-034 core_reset SHALL be asserted while reset is high and for the first cycle after reset deasserts.
REQ-035 A reset mid-operation SHALL discard the in-flight hash with no hash_valid pulse.

Structure
REQ-036 The state enum, HASH_W=256, and BYTE_W=8 SHALL live in the shared package sha256_pkg.
REQ-037 Round-robin selection SHALL be the sub-module rr_arbiter, with inputs req and last-grant and a one-hot output, purely combinational.

Verification
REQ-038 A bench SHALL cover: req=0001, stream "abc" then bytes_done -> hash_valid=0001 and hash_out=ba7816bf...f20015ad.
REQ-039 A bench SHALL cover: req=1111 held after reset -> grants in the order 0001, 0010, 0100, 1000, 0001, each completing before the next.
REQ-040 A bench SHALL cover: requester 2 granted and sending no bytes, TIMEOUT_CYCLES=16 -> abort=0100 16 cycles after STREAM entry, core_reset pulses, then the next requester is granted.
REQ-041 A bench SHALL cover: byte 0x63 with bytes_done in the same cycle -> both forwarded and the FSM in WAIT_DONE next cycle.
REQ-042 A bench SHALL cover: reset asserted in WAIT_DONE -> no hash_valid, grant=0, and requester 0 wins the next request.
REQ-043 A bench SHALL cover: the 0x00 message "" (empty, bytes_done only) -> hash_out=e3b0c442...7852b855.
